// File: rtl/seg_disp_pkg.sv
// Shared types and constants for the scrolling seven-segment display.
package seg_disp_pkg;

  typedef logic [4:0] glyph_t;

  localparam glyph_t GLYPH_BLANK = 5'h10;
  localparam glyph_t GLYPH_DASH  = 5'h11;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // All segments dark (active-low, a..g).
  localparam logic [0:6] SEG_OFF = 7'b1111111;

  // Active-low one-hot anode pattern for a digit position.
  function automatic logic [7:0] anode_onehot_low(input logic [2:0] dig);
    return ~(8'b0000_0001 << dig);
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational glyph-code to active-low a..g segment table.
module seg_glyph_decode
  import seg_disp_pkg::*;
(
  input  glyph_t     i_glyph,
  output logic [0:6] o_seg
);

  // Look up the segment pattern; unknown codes render blank.
  always_comb begin
    o_seg = SEG_OFF;
    case (i_glyph)
      5'h00:      o_seg = 7'b0000001;
      5'h01:      o_seg = 7'b1001111;
      5'h02:      o_seg = 7'b0010010;
      5'h03:      o_seg = 7'b0000110;
      5'h04:      o_seg = 7'b1001100;
      5'h05:      o_seg = 7'b0100100;
      5'h06:      o_seg = 7'b0100000;
      5'h07:      o_seg = 7'b0001111;
      5'h08:      o_seg = 7'b0000000;
      5'h09:      o_seg = 7'b0000100;
      5'h0A:      o_seg = 7'b0001000;
      5'h0B:      o_seg = 7'b1100000;
      5'h0C:      o_seg = 7'b0110001;
      5'h0D:      o_seg = 7'b1000010;
      5'h0E:      o_seg = 7'b0110000;
      5'h0F:      o_seg = 7'b0111000;
      GLYPH_DASH: o_seg = 7'b1111110;
      default:    o_seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/scroll_display_ctrl.sv
// Multiplexed seven-segment driver with a scrollable message buffer.
// The scan walks the active digits from the leftmost one to the rightmost.
module scroll_display_ctrl
  import seg_disp_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int ACTIVE_DIGITS = 4,
  parameter int MSG_LEN       = 4,
  parameter int REFRESH_DIV   = 1000,
  parameter int SCROLL_DIV    = 800000
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [4:0] wr_char,
  input  logic [1:0] mode,
  input  logic       pause,
  output logic [7:0] AN,
  output logic [0:6] HEX0,
  output logic [3:0] offset,
  output logic       scroll_wrap
);

  localparam int RW  = $clog2(REFRESH_DIV);
  localparam int SW  = $clog2(SCROLL_DIV);
  localparam int MW  = $clog2(MSG_LEN);
  localparam int LIT = (ACTIVE_DIGITS < NUM_DIGITS) ? ACTIVE_DIGITS : NUM_DIGITS;

  localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCR_LAST   = SW'(SCROLL_DIV - 1);
  localparam logic [3:0]    OFF_LAST   = 4'(MSG_LEN - 1);
  localparam logic [2:0]    SCAN_LAST  = 3'(ACTIVE_DIGITS - 1);
  localparam logic [4:0]    MSG_LEN_W  = 5'(MSG_LEN);
  localparam logic [7:0]    DIGIT_MASK = 8'((1 << LIT) - 1);

  logic [RW-1:0] r_ref_cnt;
  logic [SW-1:0] r_scr_cnt;
  logic [2:0]    r_scan;
  logic [3:0]    r_offset;
  logic          r_wrap;
  logic [7:0]    r_an;
  logic [0:6]    r_hex;
  glyph_t        r_msg [MSG_LEN];

  logic          w_ref_tick;
  logic          w_scr_tick;
  logic [2:0]    w_dig;
  logic [4:0]    w_sum;
  logic [MW-1:0] w_msg_idx;
  glyph_t        w_glyph;
  logic [0:6]    w_seg;
  logic [7:0]    w_an_next;

  assign w_ref_tick = (r_ref_cnt == REF_LAST);
  assign w_scr_tick = (r_scr_cnt == SCR_LAST);

  // Scan position s drives digit ACTIVE_DIGITS-1-s, so its character
  // index (offset + ACTIVE_DIGITS-1-digit) reduces to offset + s.
  assign w_dig     = SCAN_LAST - r_scan;
  assign w_sum     = {1'b0, r_offset} + {2'b00, r_scan};
  assign w_msg_idx = MW'(w_sum % MSG_LEN_W);
  assign w_glyph   = r_msg[w_msg_idx];
  assign w_an_next = anode_onehot_low(w_dig) | ~DIGIT_MASK;

  seg_glyph_decode u_glyph_decode (
    .i_glyph (w_glyph),
    .o_seg   (w_seg)
  );

  // Refresh divider: free-running count producing a one-cycle tick.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_ref_cnt <= {RW{1'b0}};
    end else if (w_ref_tick) begin
      r_ref_cnt <= {RW{1'b0}};
    end else begin
      r_ref_cnt <= r_ref_cnt + RW'(1);
    end
  end

  // Scroll divider: keeps counting regardless of mode or pause.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_scr_cnt <= {SW{1'b0}};
    end else if (w_scr_tick) begin
      r_scr_cnt <= {SW{1'b0}};
    end else begin
      r_scr_cnt <= r_scr_cnt + SW'(1);
    end
  end

  // On each refresh tick latch the anode/segment pair and advance the scan.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_scan <= 3'd0;
      r_an   <= 8'hFF;
      r_hex  <= SEG_OFF;
    end else if (w_ref_tick) begin
      r_an   <= w_an_next;
      r_hex  <= w_seg;
      r_scan <= (r_scan == SCAN_LAST) ? 3'd0 : r_scan + 3'd1;
    end else begin
      r_scan <= r_scan;
    end
  end

  // Step the offset on scroll ticks and flag wrap-around for one cycle.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      r_offset <= 4'd0;
      r_wrap   <= 1'b0;
    end else if (w_scr_tick && !pause) begin
      case (mode_e'(mode))
        MODE_LEFT: begin
          if (r_offset == OFF_LAST) begin
            r_offset <= 4'd0;
            r_wrap   <= 1'b1;
          end else begin
            r_offset <= r_offset + 4'd1;
            r_wrap   <= 1'b0;
          end
        end
        MODE_RIGHT: begin
          if (r_offset == 4'd0) begin
            r_offset <= OFF_LAST;
            r_wrap   <= 1'b1;
          end else begin
            r_offset <= r_offset - 4'd1;
            r_wrap   <= 1'b0;
          end
        end
        default: begin
          r_wrap <= 1'b0;
        end
      endcase
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Message buffer: writes beyond the buffer depth are dropped.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r_msg[i] <= GLYPH_BLANK;
      end
    end else if (wr_en && ({1'b0, wr_addr} < MSG_LEN_W)) begin
      r_msg[wr_addr[MW-1:0]] <= wr_char;
    end else begin
      r_msg <= r_msg;
    end
  end

  assign AN          = r_an;
  assign HEX0        = r_hex;
  assign offset      = r_offset;
  assign scroll_wrap = r_wrap;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Self-checking bench for scroll_display_ctrl with a behavioural model.
module tb_scroll_display_ctrl;

  localparam int REF = 4;
  localparam int SCR = 64;
  localparam int ACT = 4;
  localparam int LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [4:0] wr_char;
  logic [1:0] mode;
  logic       pause;
  logic [7:0] AN;
  logic [0:6] HEX0;
  logic [3:0] offset;
  logic       scroll_wrap;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  logic [4:0] m_msg [16];
  int         m_off;
  int         m_cyc;
  int         m_nref;
  logic [7:0] exp_an;
  logic [0:6] exp_hex;
  logic       exp_wrap;

  always #5 clk = ~clk;

  scroll_display_ctrl #(
    .NUM_DIGITS    (8),
    .ACTIVE_DIGITS (ACT),
    .MSG_LEN       (LEN),
    .REFRESH_DIV   (REF),
    .SCROLL_DIV    (SCR)
  ) dut (
    .CLK100MHZ   (clk),
    .CPU_RESETN  (rst_n),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_char     (wr_char),
    .mode        (mode),
    .pause       (pause),
    .AN          (AN),
    .HEX0        (HEX0),
    .offset      (offset),
    .scroll_wrap (scroll_wrap)
  );

  // Segment pattern from the list of lit segments of each glyph.
  function automatic logic [0:6] seg_ref(input logic [4:0] c);
    string      lit;
    logic [0:6] s;
    case (c)
      5'h00: lit = "abcdef";
      5'h01: lit = "bc";
      5'h02: lit = "abdeg";
      5'h03: lit = "abcdg";
      5'h04: lit = "bcfg";
      5'h05: lit = "acdfg";
      5'h06: lit = "acdefg";
      5'h07: lit = "abc";
      5'h08: lit = "abcdefg";
      5'h09: lit = "abcdfg";
      5'h0A: lit = "abcefg";
      5'h0B: lit = "cdefg";
      5'h0C: lit = "adef";
      5'h0D: lit = "bcdeg";
      5'h0E: lit = "adefg";
      5'h0F: lit = "aefg";
      5'h11: lit = "g";
      default: lit = "";
    endcase
    s = 7'b1111111;
    for (int i = 0; i < lit.len(); i++) begin
      s[int'(lit.getc(i)) - 97] = 1'b0;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_msg[i] = 5'h10;
    m_off    = 0;
    m_cyc    = 0;
    m_nref   = 0;
    exp_an   = 8'hFF;
    exp_hex  = 7'b1111111;
    exp_wrap = 1'b0;
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    int         scan;
    int         dig;
    logic [3:0] idx;
    logic [3:0] exp_off;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_cyc++;
      if (m_cyc % REF == 0) begin
        scan    = m_nref % ACT;
        dig     = ACT - 1 - scan;
        exp_an  = ~(8'b0000_0001 << dig);
        idx     = 4'((m_off + ACT - 1 - dig) % LEN);
        exp_hex = seg_ref(m_msg[idx]);
        m_nref++;
      end
      exp_wrap = 1'b0;
      if ((m_cyc % SCR == 0) && !pause) begin
        if (mode == 2'b01) begin
          exp_wrap = (m_off == LEN - 1);
          m_off    = (m_off + 1) % LEN;
        end else if (mode == 2'b10) begin
          exp_wrap = (m_off == 0);
          m_off    = (m_off + LEN - 1) % LEN;
        end
      end
      if (wr_en && (wr_addr < 4'(LEN))) m_msg[wr_addr] = wr_char;
    end
    #1;
    exp_off = 4'(m_off);
    checks++;
    if (AN !== exp_an) begin
      failures++;
      $display("FAIL an t=%0t got=%h exp=%h", $time, AN, exp_an);
    end
    checks++;
    if (HEX0 !== exp_hex) begin
      failures++;
      $display("FAIL hex t=%0t got=%b exp=%b", $time, HEX0, exp_hex);
    end
    checks++;
    if (offset !== exp_off) begin
      failures++;
      $display("FAIL offset t=%0t got=%0d exp=%0d", $time, offset, exp_off);
    end
    checks++;
    if (scroll_wrap !== exp_wrap) begin
      failures++;
      $display("FAIL wrap t=%0t got=%b exp=%b", $time, scroll_wrap, exp_wrap);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 4'd0;
    wr_char = 5'd0;
    mode    = 2'b00;
    pause   = 1'b0;
    model_reset();
    repeat (3) step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (AN[7:4] !== 4'hF) begin
        failures++;
        $display("FAIL an_upper cyc=%0d got=%h exp=f", i, AN[7:4]);
      end
      if (i == 4 || i == 8 || i == 12 || i == 16) begin
        logic [7:0] want;
        case (i)
          4:       want = 8'hF7;
          8:       want = 8'hFB;
          12:      want = 8'hFD;
          default: want = 8'hFE;
        endcase
        checks++;
        if (AN !== want || HEX0 !== 7'b1111111) begin
          failures++;
          $display("FAIL first_scan cyc=%0d got=%h/%b exp=%h/1111111", i, AN, HEX0, want);
        end
      end
    end
  endtask

  task automatic test_static();
    logic [4:0] msg_tab [4];
    logic [0:6] obs [4];
    logic [0:6] want [4];
    msg_tab[0] = 5'h0D; msg_tab[1] = 5'h0E; msg_tab[2] = 5'h01; msg_tab[3] = 5'h00;
    want[3] = 7'b1000010; want[2] = 7'b0110000; want[1] = 7'b1001111; want[0] = 7'b0000001;
    for (int d = 0; d < 4; d++) obs[d] = 7'bxxxxxxx;
    mode = 2'b00;
    for (int a = 0; a < 4; a++) begin
      wr_en   = 1'b1;
      wr_addr = 4'(a);
      wr_char = msg_tab[a];
      step();
    end
    wr_en = 1'b0;
    repeat (16) begin
      step();
      for (int d = 0; d < 4; d++) if (AN[d] == 1'b0) obs[d] = HEX0;
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (obs[d] !== want[d]) begin
        failures++;
        $display("FAIL static_digit%0d got=%b exp=%b", d, obs[d], want[d]);
      end
    end
  endtask

  task automatic test_scroll_left();
    int wraps = 0;
    mode = 2'b01;
    repeat (4 * SCR) begin
      step();
      if (scroll_wrap) wraps++;
    end
    checks++;
    if (wraps !== 1 || offset !== 4'd0) begin
      failures++;
      $display("FAIL left_cycle wraps=%0d off=%0d exp wraps=1 off=0", wraps, offset);
    end
  endtask

  task automatic test_scroll_right_pause();
    int wraps = 0;
    mode = 2'b10;
    repeat (2 * SCR) begin
      step();
      if (scroll_wrap) wraps++;
    end
    checks++;
    if (wraps !== 1 || offset !== 4'd2) begin
      failures++;
      $display("FAIL right_steps wraps=%0d off=%0d exp wraps=1 off=2", wraps, offset);
    end
    pause = 1'b1;
    wraps = 0;
    repeat (2 * SCR) begin
      step();
      if (scroll_wrap) wraps++;
    end
    checks++;
    if (wraps !== 0 || offset !== 4'd2) begin
      failures++;
      $display("FAIL pause_hold wraps=%0d off=%0d exp wraps=0 off=2", wraps, offset);
    end
    pause = 1'b0;
    mode  = 2'b00;
  endtask

  task automatic test_write_edge();
    logic found = 1'b0;
    int   pre;
    wr_en   = 1'b1;
    wr_addr = 4'd5;
    wr_char = 5'h11;
    step();
    wr_en = 1'b0;
    repeat (16) step();
    mode = 2'b01;
    for (int i = 0; i < SCR + 1 && !found; i++) begin
      if (m_cyc % SCR == SCR - 1) found = 1'b1;
      else step();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL tick_align got=0 exp=1");
    end
    pre     = m_off;
    wr_en   = 1'b1;
    wr_addr = 4'd2;
    wr_char = 5'h11;
    step();
    wr_en = 1'b0;
    checks++;
    if (offset !== 4'((pre + 1) % LEN)) begin
      failures++;
      $display("FAIL write_tick_offset got=%0d exp=%0d", offset, (pre + 1) % LEN);
    end
    mode = 2'b00;
    repeat (16) step();
  endtask

  task automatic test_random();
    repeat (1500) begin
      if ($urandom_range(0, 199) == 0) mode = 2'($urandom_range(0, 3));
      pause   = ($urandom_range(0, 3) == 0);
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = 4'($urandom_range(0, 7));
      wr_char = 5'($urandom_range(0, 31));
      step();
    end
    mode  = 2'b00;
    pause = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int blanks_bad = 0;
    mode = 2'b01;
    for (int i = 0; i < 5 * SCR && m_off != 2; i++) step();
    repeat (10) step();
    checks++;
    if (offset !== 4'd2) begin
      failures++;
      $display("FAIL pre_reset_offset got=%0d exp=2", offset);
    end
    wr_en   = 1'b1;
    wr_addr = 4'd0;
    wr_char = 5'h05;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (AN !== 8'hFF || HEX0 !== 7'b1111111 || offset !== 4'd0 || scroll_wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%0d/%b exp=ff/1111111/0/0", AN, HEX0, offset, scroll_wrap);
    end
    model_reset();
    repeat (2) step();
    wr_en = 1'b0;
    mode  = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i >= 4 && HEX0 !== 7'b1111111) blanks_bad++;
    end
    checks++;
    if (blanks_bad !== 0) begin
      failures++;
      $display("FAIL post_reset_blank got=%0d nonblank exp=0", blanks_bad);
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_scroll_left();
    test_scroll_right_pause();
    test_write_edge();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scroll_display_ctrl.md
SCROLL_DISPLAY_CTRL -- requirements
Module: scroll_display_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, 8, count of physical seven-segment digits; legal range 1..8.
REQ-002 Parameter ACTIVE_DIGITS, 4, count of rightmost digits driven; legal range 1..NUM_DIGITS.
REQ-003 Parameter MSG_LEN, 4, message buffer depth in characters; legal range 2..16.
REQ-004 Parameter REFRESH_DIV, 1000, clock cycles per digit-refresh tick; minimum 2.
REQ-005 Parameter SCROLL_DIV, 800000, clock cycles per scroll tick; minimum 2.
REQ-006 CLK100MHZ  input  1  system clock; every flop is clocked on its rising edge.
REQ-007 CPU_RESETN  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  message-buffer write strobe.
REQ-009 wr_addr  input  4  write position; 0 is the leftmost message character.
REQ-010 wr_char  input  5  glyph code to write.
REQ-011 mode  input  2  display mode: 00 static, 01 scroll-left, 10 scroll-right, 11 treated as static.
REQ-012 pause  input  1  when high, holds the scroll offset.
REQ-013 AN  output  8  digit anodes, active-low; bit 0 is the rightmost digit.
REQ-014 HEX0  output  7  segments [0:6] = a..g, active-low.
REQ-015 offset  output  4  current scroll offset.
REQ-016 scroll_wrap  output  1  one-cycle pulse when offset wraps.

Function
REQ-017 Internal counters SHALL generate single-cycle refresh and scroll enables; the design SHALL NOT use any derived clock.
REQ-018 A refresh tick SHALL fire every REFRESH_DIV cycles and advance the digit index 0..ACTIVE_DIGITS-1, wrapping to 0.
REQ-019 One cycle after each refresh tick, AN SHALL drive the indexed bit low and all other bits high, and HEX0 SHALL show that digit's glyph.
REQ-020 AN bits at and above ACTIVE_DIGITS, and bits at and above NUM_DIGITS, SHALL remain high at all times.
REQ-021 Digit d SHALL display msg[(offset + ACTIVE_DIGITS-1-d) mod MSG_LEN].
REQ-022 On a scroll tick with pause low, mode 01 SHALL increment offset modulo MSG_LEN and mode 10 SHALL decrement offset modulo MSG_LEN.
REQ-023 On a scroll tick, static mode or pause high SHALL hold offset; the scroll divider SHALL keep counting in either case.
REQ-024 scroll_wrap SHALL pulse high for one cycle when offset changes MSG_LEN-1->0 (mode 01) or 0->MSG_LEN-1 (mode 10).
REQ-025 A write with wr_en high and wr_addr < MSG_LEN SHALL update msg[wr_addr] at the next edge.
REQ-026 A write with wr_addr >= MSG_LEN SHALL be ignored.
REQ-027 A write and a scroll tick in the same cycle SHALL both take effect.
REQ-028 A written character SHALL become visible no later than the refresh tick that follows the write.
REQ-029 A mode change SHALL NOT alter offset.
REQ-030 Glyph codes 0x00-0x0F SHALL decode to hexadecimal 0-F (b and d lowercase), 0x10 to blank, 0x11 to dash, and all other codes to blank.

Reset
REQ-031 While CPU_RESETN is low: AN = 8'hFF, HEX0 = 7'b1111111, offset = 0, scroll_wrap = 0, digit index = 0, both dividers = 0, all msg entries = 0x10 (blank).
REQ-032 A reset asserted mid-scroll or mid-write SHALL abort the operation; no write SHALL be committed while reset is low.
REQ-033 The first refresh tick SHALL occur exactly REFRESH_DIV cycles after reset deasserts.

Structure
REQ-034 Package seg_disp_pkg SHALL hold the 5-bit glyph type, the glyph constants (GLYPH_BLANK = 0x10, GLYPH_DASH = 0x11) and the mode encodings.
REQ-035 Sub-module seg_glyph_decode SHALL hold the combinational glyph-to-segment table; all other logic stays in scroll_display_ctrl.

Verification
REQ-036 All scenarios use REFRESH_DIV=4, SCROLL_DIV=64, NUM_DIGITS=8, ACTIVE_DIGITS=4, MSG_LEN=4.
REQ-037 Reset released, no writes -> AN cycles F7, FB, FD, FE every 4 cycles; HEX0 = 1111111; AN[7:4] always high.
REQ-038 Write msg = {0x0D, 0x0E, 0x01, 0x00}, mode 00 -> digits show d, E, 1, 0 with HEX0 = 1000010, 0110000, 1001111, 0000001.
REQ-039 Same message, mode 01 -> offset steps 0, 1, 2, 3, 0 every 64 cycles; scroll_wrap pulses on 3->0; after one tick the digits show E, 1, 0, d.
REQ-040 Mode 10 with pause toggled -> offset steps 0, 3, 2 with scroll_wrap on 0->3; pause high holds 2 across two scroll ticks.
REQ-041 wr_addr = 5 with wr_en high -> buffer unchanged; a write to addr 2 coinciding with a scroll tick -> both the write and the offset step are applied.
REQ-042 CPU_RESETN pulsed low mid-scroll at offset 2 -> outputs at reset values immediately (asynchronously); buffer all blank after release.
